// File: rtl/cook_timer_ctrl.sv
// Microwave cook-timer controller: keypad time/power entry, BCD countdown with
// minute/second borrow, pause/resume, power-level duty cycling and 7-seg decode.
module cook_timer_ctrl #(
  parameter int DIGITS         = 4,
  parameter int TICKS_PER_SEC  = 50,
  parameter int QUICK_SEC_TENS = 3
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [9:0]            keypad,
  input  logic                  power_set,
  input  logic                  startn,
  input  logic                  stopn,
  input  logic                  door_closed,
  output logic                  mag,
  output logic                  timer_done,
  output logic                  cooking,
  output logic [3:0]            power_lvl,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   segs
);

  localparam int                PW           = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]     LP_TC        = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]        LP_QUICK     = 4'(QUICK_SEC_TENS);
  localparam logic [4*DIGITS-1:0] LP_QUICK_BCD = {{(4*DIGITS-8){1'b0}}, LP_QUICK, 4'd0};

  typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [9:0]          r_key_q, r_key_prev;
  logic                r_startn_q, r_startn_prev, r_stopn_q, r_stopn_prev;
  logic [4*DIGITS-1:0] r_bcd, w_dec_bcd;
  logic [PW-1:0]       r_presc;
  logic [3:0]          r_phase, r_power, w_key_val;
  logic                w_key_ok, w_start, w_stop, w_borrow, w_tc;
  logic                w_time_zero, w_dec_zero, w_hold, w_start_go;

  assign w_key_ok    = (r_key_prev == 10'd0) && $onehot(r_key_q);
  assign w_start     = r_startn_prev & ~r_startn_q;
  assign w_stop      = r_stopn_prev & ~r_stopn_q;
  assign w_tc        = (r_presc == LP_TC);
  assign w_time_zero = (r_bcd == '0);
  assign w_dec_zero  = (w_dec_bcd == '0);
  // Stop outranks start everywhere; door open also freezes an active cook.
  assign w_hold      = w_stop | ~door_closed;
  assign w_start_go  = w_start & ~w_stop & door_closed;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_key_q       <= '0;
      r_key_prev    <= '0;
      r_startn_q    <= 1'b1;
      r_startn_prev <= 1'b1;
      r_stopn_q     <= 1'b1;
      r_stopn_prev  <= 1'b1;
    end else begin
      r_key_q       <= keypad;
      r_key_prev    <= r_key_q;
      r_startn_q    <= startn;
      r_startn_prev <= r_startn_q;
      r_stopn_q     <= stopn;
      r_stopn_prev  <= r_stopn_q;
    end
  end

  always_comb begin
    w_key_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_key_q[i]) w_key_val = 4'(i);
    end
  end

  // Sec tens reloads to 5 on borrow; every other digit reloads to 9.
  always_comb begin
    w_dec_bcd = r_bcd;
    w_borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_borrow) begin
        if (r_bcd[4*i +: 4] == 4'd0) begin
          w_dec_bcd[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          w_dec_bcd[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
          w_borrow            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_go) w_state_next = S_COOK;
      S_COOK: begin
        if (w_hold)                 w_state_next = S_PAUSE;
        else if (w_tc && w_dec_zero) w_state_next = S_DONE;
      end
      S_PAUSE: begin
        if (w_stop)          w_state_next = S_IDLE;
        else if (w_start_go) w_state_next = S_COOK;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cooking    = (r_state == S_COOK);
    timer_done = (r_state == S_DONE);
    mag        = (r_state == S_COOK) && door_closed && (r_phase < r_power);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_bcd   <= '0;
      r_presc <= '0;
      r_phase <= 4'd0;
      r_power <= 4'd10;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_stop) begin
            r_bcd   <= '0;
            r_power <= 4'd10;
          end else if (w_start_go) begin
            r_presc <= '0;
            r_phase <= 4'd0;
            if (w_time_zero) r_bcd <= LP_QUICK_BCD;
          end else if (w_key_ok) begin
            if (power_set) r_power <= (w_key_val == 4'd0) ? 4'd10 : w_key_val;
            else           r_bcd   <= {r_bcd[4*DIGITS-5:0], w_key_val};
          end
        end
        S_COOK: begin
          if (!w_hold) begin
            if (w_tc) begin
              r_presc <= '0;
              r_phase <= (r_phase == 4'd9) ? 4'd0 : r_phase + 4'd1;
              r_bcd   <= w_dec_bcd;
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
        end
        S_PAUSE: if (w_stop) r_bcd <= '0;
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    case (d)
      4'd0:    f_seg7 = 7'b0111111;
      4'd1:    f_seg7 = 7'b0000110;
      4'd2:    f_seg7 = 7'b1011011;
      4'd3:    f_seg7 = 7'b1001111;
      4'd4:    f_seg7 = 7'b1100110;
      4'd5:    f_seg7 = 7'b1101101;
      4'd6:    f_seg7 = 7'b1111101;
      4'd7:    f_seg7 = 7'b0000111;
      4'd8:    f_seg7 = 7'b1111111;
      4'd9:    f_seg7 = 7'b1101111;
      default: f_seg7 = 7'b0000000;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign segs[7*gi +: 7] = f_seg7(r_bcd[4*gi +: 4]);
    end
  endgenerate

  assign bcd       = r_bcd;
  assign power_lvl = r_power;

endmodule
